uart_tx_buffered: RTL

// - Serialises bytes onto the UART tx line as 8N1 frames: start bit, 8 data bits LSB first, stop bit.
// - A small FIFO decouples the CPU from line timing, so the CPU can queue several bytes without stalling.
// - Sits beside the UART receiver in the I/O block and uses the same level go/done handshake
//   (done is the transmit-side counterpart of the receiver's dr).

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_tx_buffered_if.sv | 15 +
 rtl/uart_tx_fifo.sv | 61 ++++++
 rtl/uart_tx_buffered.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
package uart_pkg;

  localparam int   DATA_BITS = 8;
  localparam logic LINE_IDLE = 1'b1;

  typedef enum logic [2:0] {
    SH_IDLE,
    SH_START,
    SH_DATA,
    SH_PARITY,
    SH_STOP
  } shift_state_e;

  typedef enum logic {
    ACCEPT_IDLE,
    ACCEPT_WAIT_GO_LOW
  } accept_state_e;

  // Even parity: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// CPU-side go/done enqueue handshake plus FIFO status for the UART transmitter.
interface uart_tx_buffered_if #(
  parameter int FIFO_DEPTH = 4
) ();
  import uart_pkg::*;

  logic                               go;
  logic [DATA_BITS-1:0]               data;
  logic                               done;
  logic                               busy;
  logic [$clog2(FIFO_DEPTH+1)-1:0]    level;

  modport master (output go, data, input done, busy, level);
  modport slave  (input go, data, output done, busy, level);
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO holding bytes queued for transmission; async active-low clear.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  logic [WIDTH-1:0]               push_data,
  input  logic                           pop,
  output logic [WIDTH-1:0]               pop_data,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     level
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;

  // Advance pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointer and occupancy registers, cleared immediately by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is not reset; the empty flag keeps stale entries from being read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign full     = (level_q == LW'(DEPTH));
  assign empty    = (level_q == '0);
  assign level    = level_q;

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: go/done enqueue into a FIFO, 8N1 serialiser drains it.
// Optional feature macro: UART_TX_PARITY_EN adds an even parity bit after data bit 7.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 66_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             tx,
  uart_tx_buffered_if.slave bus
);
  localparam int BIT_TIME = CLK_FREQ / BAUD_RATE;
  localparam int CW       = (BIT_TIME > 1) ? $clog2(BIT_TIME) : 1;
  localparam int LW       = $clog2(FIFO_DEPTH+1);
  localparam logic [CW-1:0] CNT_RELOAD = CW'(BIT_TIME - 1);
  localparam logic [2:0]    LAST_BIT   = 3'(DATA_BITS - 1);

  accept_state_e        accept_q, accept_d;
  logic                 done_q, done_d;
  shift_state_e         state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;

  logic                 push, pop;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 fifo_full, fifo_empty;
  logic [LW-1:0]        fifo_level, level_next;

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_BITS)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (bus.data),
    .pop       (pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Accept one byte per go pulse; a full FIFO stalls the handshake until space frees.
  always_comb begin
    accept_d = accept_q;
    done_d   = done_q;
    push     = 1'b0;
    case (accept_q)
      ACCEPT_IDLE: begin
        if (bus.go && !fifo_full) begin
          push     = 1'b1;
          done_d   = 1'b1;
          accept_d = ACCEPT_WAIT_GO_LOW;
        end
      end
      ACCEPT_WAIT_GO_LOW: begin
        if (!bus.go) begin
          done_d   = 1'b0;
          accept_d = ACCEPT_IDLE;
        end
      end
      default: begin
        done_d   = 1'b0;
        accept_d = ACCEPT_IDLE;
      end
    endcase
  end

  // Serialiser: each line bit lasts BIT_TIME cycles; back-to-back frames chain from STOP.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    case (state_q)
      SH_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_rdata;
          tx_d    = 1'b0;
          cnt_d   = CNT_RELOAD;
          state_d = SH_START;
        end
      end
      SH_START: begin
        if (cnt_q == '0) begin
          tx_d      = shift_q[0];
          cnt_d     = CNT_RELOAD;
          bit_idx_d = 3'd0;
          state_d   = SH_DATA;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      SH_DATA: begin
        if (cnt_q == '0) begin
          cnt_d = CNT_RELOAD;
          if (bit_idx_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = even_parity(shift_q);
            state_d = SH_PARITY;
`else
            tx_d    = LINE_IDLE;
            state_d = SH_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[bit_idx_d];
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      SH_PARITY: begin
        if (cnt_q == '0) begin
          tx_d    = LINE_IDLE;
          cnt_d   = CNT_RELOAD;
          state_d = SH_STOP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
`endif
      SH_STOP: begin
        if (cnt_q == '0) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_rdata;
            tx_d    = 1'b0;
            cnt_d   = CNT_RELOAD;
            state_d = SH_START;
          end else begin
            state_d = SH_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        tx_d    = LINE_IDLE;
        state_d = SH_IDLE;
      end
    endcase
  end

  // Busy reflects post-edge occupancy and serialiser activity, so compute next-cycle values.
  always_comb begin
    level_next = fifo_level;
    case ({push, pop})
      2'b10:   level_next = fifo_level + LW'(1);
      2'b01:   level_next = fifo_level - LW'(1);
      default: level_next = fifo_level;
    endcase
    busy_d = (level_next != '0) || (state_d != SH_IDLE);
  end

  // All control state; reset truncates any frame in flight and returns the line high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accept_q  <= ACCEPT_IDLE;
      done_q    <= 1'b0;
      state_q   <= SH_IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      tx_q      <= LINE_IDLE;
      busy_q    <= 1'b0;
    end else begin
      accept_q  <= accept_d;
      done_q    <= done_d;
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign tx        = tx_q;
  assign bus.done  = done_q;
  assign bus.busy  = busy_q;
  assign bus.level = fifo_level;

endmodule
